// File: rtl/lrshift_engine.sv
// ---------------------------------------------------------------------------
// lrshift_engine
//
// Purpose:
//   A WIDTH-bit register with parallel load and a sequenced shift/rotate
//   engine. A command applies one single-bit step per clock for a commanded
//   amount. It is a cheaper alternative to a full barrel shifter wherever a
//   variable-distance shift or a serial stream is needed.
//
// Ports:
//   clk     in   clock; all state updates on the rising edge
//   reset   in   synchronous active-high reset; clears all state
//   load    in   parallel load request (honoured only when idle)
//   din     in   WIDTH-bit parallel load data
//   start   in   shift command request (honoured only when idle, load=0)
//   op      in   3-bit operation: 000 SRL, 001 SLL, 010 SRA, 011 ROR,
//                100 ROL, 101..111 behave as a zero-length command
//   amount  in   AMT_W-bit number of single-bit steps
//   sin     in   serial fill bit for SRL/SLL, sampled on every shifting edge
//   out     out  register contents
//   sout    out  bit shifted out on the most recent shifting edge
//   busy    out  high while further shift steps remain
//   done    out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module lrshift_engine #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amount,
    input  logic             sin,
    output logic [WIDTH-1:0] out,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [2:0] OP_SRL = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;

    localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

    state_t           state_q, state_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             sout_q, sout_d;
    logic             done_q, done_d;

    logic [2:0]       stepOp;
    logic [WIDTH-1:0] stepOut;
    logic             stepSout;
    logic             cmdIsNull;

    // The first step happens on the accepting edge, before op is latched,
    // so the step logic must look at the live op input while idle.
    assign stepOp = (state_q == SHIFT) ? op_q : op;

    // Zero amounts and unused op codes complete immediately without touching data.
    assign cmdIsNull = (amount == '0) || (op > OP_ROL);

    // One single-bit step of the selected operation.
    always_comb begin
        stepOut  = out_q;
        stepSout = sout_q;
        case (stepOp)
            OP_SRL: begin
                stepOut  = {sin, out_q[WIDTH-1:1]};
                stepSout = out_q[0];
            end
            OP_SLL: begin
                stepOut  = {out_q[WIDTH-2:0], sin};
                stepSout = out_q[WIDTH-1];
            end
            OP_SRA: begin
                stepOut  = {out_q[WIDTH-1], out_q[WIDTH-1:1]};
                stepSout = out_q[0];
            end
            OP_ROR: begin
                stepOut  = {out_q[0], out_q[WIDTH-1:1]};
                stepSout = out_q[0];
            end
            OP_ROL: begin
                stepOut  = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
                stepSout = out_q[WIDTH-1];
            end
            default: begin
                stepOut  = out_q;
                stepSout = sout_q;
            end
        endcase
    end

    // Next-state logic. count_q holds the steps still to perform after the
    // current edge; the engine leaves SHIFT on the edge that performs the
    // last one, which is when done is raised.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        out_d   = out_q;
        sout_d  = sout_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    out_d = din;
                end else if (start) begin
                    op_d = op;
                    if (cmdIsNull) begin
                        done_d = 1'b1;
                    end else begin
                        out_d  = stepOut;
                        sout_d = stepSout;
                        if (amount == AMT_ONE) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = SHIFT;
                            count_d = amount - AMT_ONE;
                        end
                    end
                end
            end
            SHIFT: begin
                out_d   = stepOut;
                sout_d  = stepSout;
                count_d = count_q - AMT_ONE;
                if (count_q == AMT_ONE) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // State registers with synchronous reset; reset aborts any command silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            op_q    <= OP_SRL;
            out_q   <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            out_q   <= out_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

    assign out  = out_q;
    assign sout = sout_q;
    assign busy = (state_q == SHIFT);
    assign done = done_q;

endmodule

// File: tb/tb_lrshift_engine.sv
// ---------------------------------------------------------------------------
// tb_lrshift_engine
//
// Purpose:
//   Directed self-checking bench for lrshift_engine (WIDTH=16, AMT_W=5).
//   Expected register values below are worked out by hand from the
//   operation definitions.
// ---------------------------------------------------------------------------
module tb_lrshift_engine;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] din;
    logic        start;
    logic [2:0]  op;
    logic [4:0]  amount;
    logic        sin;
    logic [15:0] out;
    logic        sout;
    logic        busy;
    logic        done;

    int checkCount;
    int errorCount;

    lrshift_engine #(
        .WIDTH(16),
        .AMT_W(5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .din   (din),
        .start (start),
        .op    (op),
        .amount(amount),
        .sin   (sin),
        .out   (out),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it, so inputs changed
    // afterwards are set up for the next edge and outputs are stable to sample.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic loadValue(input logic [15:0] value);
        load = 1'b1;
        din  = value;
        tick();
        load = 1'b0;
    endtask

    // Issue one command and follow it to completion: counts busy cycles
    // (bounded), then checks the done cycle and the quiet cycle after it.
    // With pulseMid set, start is held high while busy to prove it is ignored.
    task automatic applyStimulus(input string tag, input logic [2:0] opV,
                                 input logic [4:0] amtV, input logic sinV,
                                 input logic pulseMid, input logic [15:0] expOut,
                                 input logic expSout, input int expBusy);
        int   busyCycles;
        int   guard;
        logic overlap;
        busyCycles = 0;
        guard      = 0;
        overlap    = 1'b0;
        op     = opV;
        amount = amtV;
        sin    = sinV;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        while (busy && guard < 100) begin
            if (done) overlap = 1'b1;
            busyCycles++;
            guard++;
            start = pulseMid;
            tick();
        end
        start = 1'b0;
        checkOutput({tag, " busyCycles"}, busyCycles, expBusy);
        checkOutput({tag, " busyDoneOverlap"}, {31'd0, overlap}, 32'd0);
        checkOutput({tag, " done"}, {31'd0, done}, 32'd1);
        checkOutput({tag, " busyAtDone"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, " out"}, {16'd0, out}, {16'd0, expOut});
        checkOutput({tag, " sout"}, {31'd0, sout}, {31'd0, expSout});
        tick();
        checkOutput({tag, " doneAfter"}, {31'd0, done}, 32'd0);
        checkOutput({tag, " busyAfter"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, " outAfter"}, {16'd0, out}, {16'd0, expOut});
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset  = 1'b1;
        load   = 1'b0;
        din    = '0;
        start  = 1'b0;
        op     = '0;
        amount = '0;
        sin    = 1'b0;
        tick();
        tick();
        checkOutput("reset out", {16'd0, out}, 32'd0);
        checkOutput("reset sout", {31'd0, sout}, 32'd0);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        reset = 1'b0;

        // Parallel load.
        loadValue(16'hA5C3);
        checkOutput("load out", {16'd0, out}, 32'h0000A5C3);
        checkOutput("load busy", {31'd0, busy}, 32'd0);
        checkOutput("load done", {31'd0, done}, 32'd0);
        checkOutput("load sout", {31'd0, sout}, 32'd0);

        // SLL by 4: A5C3 -> 4B86 -> 970C -> 2E18 -> 5C30; last bit out is 0.
        applyStimulus("sll4", 3'b001, 5'd4, 1'b0, 1'b0, 16'h5C30, 1'b0, 3);

        // SRA by 3: 8001 -> C000 -> E000 -> F000.
        loadValue(16'h8001);
        applyStimulus("sra3", 3'b010, 5'd3, 1'b0, 1'b0, 16'hF000, 1'b0, 2);

        // SRL by 3 with sin=1 gives the same pattern.
        loadValue(16'h8001);
        applyStimulus("srl3", 3'b000, 5'd3, 1'b1, 1'b0, 16'hF000, 1'b0, 2);

        // SRA by 17 (beyond WIDTH) of 8000 fills with MSB; the last bit out is 1.
        loadValue(16'h8000);
        applyStimulus("sra17", 3'b010, 5'd17, 1'b0, 1'b0, 16'hFFFF, 1'b1, 16);

        // Load must leave sout alone.
        loadValue(16'h1234);
        checkOutput("load keeps sout", {31'd0, sout}, 32'd1);

        // ROR by WIDTH returns the original value, start pulses ignored while busy.
        // The last bit out is bit0 of ror15(1234)=2468, i.e. 0.
        applyStimulus("ror16", 3'b011, 5'd16, 1'b0, 1'b1, 16'h1234, 1'b0, 15);

        // Zero amount and illegal op: no data change, immediate done.
        applyStimulus("amt0", 3'b000, 5'd0, 1'b1, 1'b0, 16'h1234, 1'b0, 0);
        applyStimulus("op101", 3'b101, 5'd7, 1'b1, 1'b0, 16'h1234, 1'b0, 0);

        // Single step: no busy, done right away. 1234 ror 1 -> 091A, out bit 0.
        applyStimulus("ror1", 3'b011, 5'd1, 1'b0, 1'b0, 16'h091A, 1'b0, 0);

        // Load and start together: load wins, command is dropped.
        load   = 1'b1;
        din    = 16'h0F0F;
        start  = 1'b1;
        op     = 3'b000;
        amount = 5'd1;
        tick();
        load   = 1'b0;
        start  = 1'b0;
        checkOutput("loadStart out", {16'd0, out}, 32'h00000F0F);
        checkOutput("loadStart done", {31'd0, done}, 32'd0);
        checkOutput("loadStart busy", {31'd0, busy}, 32'd0);
        tick();
        checkOutput("loadStart doneLater", {31'd0, done}, 32'd0);
        checkOutput("loadStart outLater", {16'd0, out}, 32'h00000F0F);

        // SLL beyond WIDTH with sin=0 clears the register.
        loadValue(16'hFFFF);
        applyStimulus("sll20", 3'b001, 5'd20, 1'b0, 1'b0, 16'h0000, 1'b0, 19);

        // Reset in the middle of a command aborts it with no done.
        loadValue(16'hFFFF);
        op     = 3'b000;
        amount = 5'd5;
        sin    = 1'b0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        checkOutput("abort firstStep", {16'd0, out}, 32'h00007FFF);
        tick();
        checkOutput("abort busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("abort out", {16'd0, out}, 32'd0);
        checkOutput("abort busyCleared", {31'd0, busy}, 32'd0);
        checkOutput("abort done", {31'd0, done}, 32'd0);
        checkOutput("abort sout", {31'd0, sout}, 32'd0);
        tick();
        checkOutput("abort doneLater", {31'd0, done}, 32'd0);

        // Normal operation afterwards: ROL by 4 of 00F0 -> 0F00; last bit out 0.
        loadValue(16'h00F0);
        applyStimulus("rol4", 3'b100, 5'd4, 1'b0, 1'b0, 16'h0F00, 1'b0, 3);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
